uart_frame_top: RTL and testbench

- Board-level top for the FFT bring-up path.
- Receives a frame of N signed samples (bit_width bits each) over a UART 8N1 line into an internal buffer.
- When key[0] is high, transmits the completed frame back on tx_o, standing in for the FFT core result stream.
- Shows frame count on a 4-digit 7-segment display and status on 4 LEDs.

---
 rtl/uart_frame_top.sv | 175 +++++++++++++++++
 tb/tb_uart_frame_top.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uart_frame_top.sv
// uart_frame_top: UART frame capture into a sample buffer and echo on key[0]; 7-segment scan of frame count when SEG_SCAN_EN is defined
module uart_frame_top #(
  parameter int bit_width = 24,
  parameter int N = 16,
  parameter int CLKS_PER_BIT = 434,
  parameter int SCAN_DIV = 50000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       data_in,
  input  logic [3:0] key,
  output logic [3:0] led,
  output logic [3:0] dig,
  output logic [7:0] seg,
  output logic       tx_o
);
  localparam int B = bit_width / 8;
  localparam int IW = $clog2(N);
  localparam int BW = B > 1 ? $clog2(B) : 1;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_t;
  typedef enum logic [1:0] {FILL, WAIT, SEND} st_t;
  logic rx_meta, rx_s, rx_q, rx_valid, frame_err;
  rx_t rx_st;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic [2:0] rx_bit;
  logic [7:0] rx_sh;
  st_t st;
  logic [IW-1:0] wr_idx, rd_idx, rd_sel;
  logic [BW-1:0] byte_idx, tx_bcnt;
  logic [bit_width-1:0] samp, w_next, tx_word, tx_src;
  logic [bit_width-1:0] buffer [N];
  logic [15:0] frame_cnt;
  logic [8:0] tx_sh;
  logic [3:0] tx_bit;
  logic byte_last, tx_last;
  assign byte_last = byte_idx == BW'(B - 1);
  assign w_next = (samp >> 8) | (bit_width'(rx_sh) << (bit_width - 8));
  assign rd_sel = st == SEND ? rd_idx + IW'(1) : '0;
  assign tx_src = buffer[rd_sel];
  assign tx_last = rd_idx == IW'(N - 1) && tx_bcnt == BW'(B - 1);
  // Synchronise the line and decode 8N1 bytes, sampling mid-bit
  always_ff @(posedge CLK or posedge RST_N)
    if (RST_N) begin
      rx_meta <= 1'b1;
      rx_s <= 1'b1;
      rx_q <= 1'b1;
      rx_st <= R_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta <= data_in;
      rx_s <= rx_meta;
      rx_q <= rx_s;
      rx_valid <= 1'b0;
      case (rx_st)
        R_IDLE: if (rx_q && !rx_s) begin
          rx_st <= R_START;
          rx_cnt <= '0;
        end
        R_START: if (rx_cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
          rx_cnt <= '0;
          rx_bit <= '0;
          rx_st <= rx_s ? R_IDLE : R_DATA;
        end else rx_cnt <= rx_cnt + CW'(1);
        R_DATA: if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
          rx_cnt <= '0;
          rx_sh <= {rx_s, rx_sh[7:1]};
          rx_bit <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_st <= R_STOP;
        end else rx_cnt <= rx_cnt + CW'(1);
        default: if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
          rx_st <= R_IDLE;
          rx_valid <= rx_s;
          frame_err <= frame_err | !rx_s;
        end else rx_cnt <= rx_cnt + CW'(1);
      endcase
    end
  // Sample store; contents are not reset
  always_ff @(posedge CLK)
    if (st == FILL && rx_valid && byte_last) buffer[wr_idx] <= w_next;
  // Frame FSM: assemble samples, wait for run enable, then stream the frame back
  always_ff @(posedge CLK or posedge RST_N)
    if (RST_N) begin
      st <= FILL;
      wr_idx <= '0;
      rd_idx <= '0;
      byte_idx <= '0;
      tx_bcnt <= '0;
      samp <= '0;
      tx_word <= '0;
      frame_cnt <= '0;
      tx_sh <= '1;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_o <= 1'b1;
      led <= '0;
    end else begin
      led <= {key[0], frame_err, st != FILL, st == FILL && (wr_idx != '0 || byte_idx != '0)};
      if (key[1]) frame_cnt <= '0;
      case (st)
        FILL: if (rx_valid) begin
          samp <= w_next;
          byte_idx <= byte_last ? '0 : byte_idx + BW'(1);
          if (byte_last) begin
            wr_idx <= wr_idx + IW'(1);
            if (wr_idx == IW'(N - 1)) begin
              st <= WAIT;
              if (!key[1]) frame_cnt <= frame_cnt + 16'd1;
            end
          end
        end
        WAIT: if (key[0]) begin
          st <= SEND;
          tx_o <= 1'b0;
          tx_sh <= {1'b1, tx_src[7:0]};
          tx_word <= tx_src >> 8;
          rd_idx <= '0;
          tx_bcnt <= '0;
          tx_cnt <= '0;
          tx_bit <= '0;
        end
        default: if (tx_cnt == CW'(CLKS_PER_BIT - 1)) begin
          tx_cnt <= '0;
          if (tx_bit == 4'd9) begin
            tx_bit <= '0;
            if (tx_last) st <= FILL;
            else begin
              tx_o <= 1'b0;
              tx_bcnt <= tx_bcnt == BW'(B - 1) ? '0 : tx_bcnt + BW'(1);
              rd_idx <= tx_bcnt == BW'(B - 1) ? rd_sel : rd_idx;
              tx_sh <= {1'b1, tx_bcnt == BW'(B - 1) ? tx_src[7:0] : tx_word[7:0]};
              tx_word <= (tx_bcnt == BW'(B - 1) ? tx_src : tx_word) >> 8;
            end
          end else begin
            tx_o <= tx_sh[0];
            tx_sh <= tx_sh >> 1;
            tx_bit <= tx_bit + 4'd1;
          end
        end else tx_cnt <= tx_cnt + CW'(1);
      endcase
    end
`ifdef SEG_SCAN_EN
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [SW-1:0] scan_cnt;
  logic [1:0] sel;
  logic [3:0] nib;
  logic [1:0] unused_keys;
  assign unused_keys = key[3:2];
  assign nib = 4'(frame_cnt >> {sel, 2'b00});
  // Rotate one active-low digit per scan slot, least significant nibble first
  always_ff @(posedge CLK or posedge RST_N)
    if (RST_N) begin
      scan_cnt <= '0;
      sel <= '0;
      dig <= 4'b1111;
      seg <= 8'hFF;
    end else begin
      dig <= ~(4'b0001 << sel);
      seg <= GLYPH[nib];
      scan_cnt <= scan_cnt == SW'(SCAN_DIV - 1) ? '0 : scan_cnt + SW'(1);
      if (scan_cnt == SW'(SCAN_DIV - 1)) sel <= sel + 2'd1;
    end
`else
  logic unused_disp;
  assign unused_disp = ^{key[3:2], frame_cnt, SCAN_DIV[0]};
  assign dig = 4'b1111;
  assign seg = 8'hFF;
`endif
endmodule

// File: tb/tb_uart_frame_top.sv
// tb_uart_frame_top: frame capture/echo bench with tx scoreboard and per-frame vector table
module tb_uart_frame_top;
  localparam int CPB = 8;
  localparam int NS = 16;
  localparam int BWID = 24;
  localparam int NB = NS * BWID / 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic [3:0] key = '0;
  logic [3:0] led, dig;
  logic [7:0] seg;
  logic tx;
  always #5 clk = ~clk;
  uart_frame_top #(.bit_width(BWID), .N(NS), .CLKS_PER_BIT(CPB), .SCAN_DIV(4)) dut (
    .CLK(clk), .RST_N(rst), .data_in(rx), .key(key), .led(led), .dig(dig), .seg(seg), .tx_o(tx)
  );
  typedef struct {
    logic [7:0] seed;
    logic [7:0] step;
    bit bad_first;
    bit drop_key;
    bit clr_at_full;
    logic [15:0] exp_cnt;
    logic exp_err;
  } vec_t;
  vec_t vecs [4];
  logic [7:0] q [$];
  int errs = 0;
  int checks = 0;
  bit mon_off = 1'b0;
  logic [7:0] mon_b;
  logic mon_ok;
`ifdef SEG_SCAN_EN
  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    if (!stop_ok) begin
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  initial forever begin
    @(negedge tx);
    repeat (CPB / 2) @(posedge clk);
    #1 mon_ok = !tx;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk);
      #1 mon_b[i] = tx;
    end
    repeat (CPB) @(posedge clk);
    #1 mon_ok = mon_ok & tx;
    if (!mon_off) begin
      if (q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL tx_unexpected: got byte %h with nothing expected", mon_b);
      end else chk("tx_byte", {23'd0, mon_ok, mon_b}, {23'd0, 1'b1, q.pop_front()});
    end
  end

  initial begin
    logic [7:0] b;
    logic [3:0] expd;
    logic [15:0] tmp;
    bit idle;
    int n;
    vecs[0] = '{8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 16'd1, 1'b0};
    vecs[1] = '{8'hA5, 8'h3B, 1'b1, 1'b1, 1'b0, 16'd2, 1'b1};
    vecs[2] = '{8'hFF, 8'h80, 1'b0, 1'b0, 1'b1, 16'd0, 1'b1};
    vecs[3] = '{8'h00, 8'h11, 1'b0, 1'b0, 1'b0, 16'd1, 1'b1};
    @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_led", led, 0);
    chk("rst_dig", dig, 4'hF);
    chk("rst_seg", seg, 8'hFF);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_led", led, 0);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("glitch_led", led, 0);
    for (int v = 0; v < 4; v++) begin
      if (vecs[v].bad_first) send_byte(8'h5A, 1'b0);
      for (int i = 0; i < NB; i++) begin
        b = vecs[v].seed + 8'(vecs[v].step * i);
        if (vecs[v].clr_at_full && i == NB - 1) key[1] = 1'b1;
        q.push_back(b);
        send_byte(b, 1'b1);
        if (v == 0 && i == 2) chk("partial_led", led, 4'b0001);
      end
      repeat (2) @(negedge clk);
      key[1] = 1'b0;
      chk("full_led", led, {28'd0, 1'b0, vecs[v].exp_err, 2'b10});
      idle = 1'b1;
      repeat (40) begin
        @(negedge clk);
        idle &= tx;
      end
      chk("wait_tx_idle", idle, 1);
`ifdef SEG_SCAN_EN
      n = 0;
      while (dig != 4'b0111 && n < 40) begin @(negedge clk); n++; end
      while (dig != 4'b1110 && n < 40) begin @(negedge clk); n++; end
      chk("scan_sync", n < 40, 1);
      for (int d = 0; d < 4; d++)
        for (int c = 0; c < 4; c++) begin
          expd = ~(4'b0001 << d);
          tmp = vecs[v].exp_cnt >> (4 * d);
          chk("scan_dig", dig, expd);
          chk("scan_seg", seg, glyph[tmp[3:0]]);
          @(negedge clk);
        end
`else
      chk("dig_off", dig, 4'hF);
      chk("seg_off", seg, 8'hFF);
`endif
      key[0] = 1'b1;
      if (vecs[v].drop_key) begin
        repeat (CPB * 10 * 5) @(negedge clk);
        key[0] = 1'b0;
      end
      n = 0;
      while (led[1] && n < 6000) begin @(negedge clk); n++; end
      chk("send_done", led[1], 0);
      chk("sb_empty", q.size(), 0);
      chk("err_led", led[2], vecs[v].exp_err);
      key[0] = 1'b0;
      repeat (2) @(negedge clk);
    end
    mon_off = 1'b1;
    for (int i = 0; i < NB; i++) send_byte(8'(i * 16), 1'b1);
    repeat (2) @(negedge clk);
    key[0] = 1'b1;
    n = 0;
    while (tx && n < 100) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    chk("midbyte_tx_low", tx, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tx", tx, 1);
    chk("async_rst_led", led, 0);
    chk("async_rst_dig", dig, 4'hF);
    chk("async_rst_seg", seg, 8'hFF);
    @(negedge clk);
    rst = 1'b0;
    key[0] = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
